// File: rtl/beam_scan_controller.sv
`timescale 1ns/1ps
// beam_scan_controller
// Steps the beamformer through a sweep of steering angles, discards samples
// while the delay lines refill, integrates |sample| over a dwell window for
// each angle and reports the angle with the highest energy.
module beam_scan_controller #(
  parameter int unsigned ANGLE_MIN      = 0,
  parameter int unsigned ANGLE_MAX      = 180,
  parameter int unsigned ANGLE_STEP     = 10,
  parameter int unsigned SETTLE_SAMPLES = 64,
  parameter int unsigned DWELL_SAMPLES  = 1024,
  parameter int unsigned AUDIO_WIDTH    = 24,
  parameter int unsigned ACC_WIDTH      = 40
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   start_in,
  input  logic                   abort_in,
  input  logic                   manual_mode_in,
  input  logic [7:0]             manual_angle_in,
  input  logic [AUDIO_WIDTH-1:0] dss_audio_in,
  input  logic                   dss_valid_in,
  output logic [7:0]             angle_out,
  output logic                   busy_out,
  output logic [ACC_WIDTH-1:0]   energy_out,
  output logic                   energy_valid_out,
  output logic [7:0]             best_angle_out,
  output logic [ACC_WIDTH-1:0]   best_energy_out,
  output logic                   done_out
);

  localparam int unsigned CNT_MAX = (SETTLE_SAMPLES > DWELL_SAMPLES) ? SETTLE_SAMPLES : DWELL_SAMPLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]          SETTLE_LAST = CW'(SETTLE_SAMPLES - 1);
  localparam logic [CW-1:0]          DWELL_LAST  = CW'(DWELL_SAMPLES - 1);
  localparam logic [CW-1:0]          CNT_ONE     = CW'(1);
  localparam logic [AUDIO_WIDTH-1:0] AUDIO_ONE   = AUDIO_WIDTH'(1);
  localparam logic [7:0]             ANGLE_MIN8  = 8'(ANGLE_MIN);
  localparam logic [8:0]             ANGLE_MAX9  = 9'(ANGLE_MAX);
  localparam logic [8:0]             ANGLE_STEP9 = 9'(ANGLE_STEP);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DWELL,
    COMPARE
  } state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [ACC_WIDTH-1:0]   acc, acc_nxt;
  logic [7:0]             scratch_angle, scratch_angle_nxt;
  logic [ACC_WIDTH-1:0]   scratch_energy, scratch_energy_nxt;

  logic [7:0]             angle_nxt;
  logic                   busy_nxt;
  logic [ACC_WIDTH-1:0]   energy_nxt;
  logic                   energy_valid_nxt;
  logic [7:0]             best_angle_nxt;
  logic [ACC_WIDTH-1:0]   best_energy_nxt;
  logic                   done_nxt;

  logic                   sample_neg;
  logic                   sample_most_neg;
  logic [AUDIO_WIDTH-1:0] sample_mag;
  logic [ACC_WIDTH:0]     acc_sum;
  logic [ACC_WIDTH-1:0]   acc_sat;
  logic                   better;
  logic [7:0]             cand_angle;
  logic [ACC_WIDTH-1:0]   cand_energy;
  logic [8:0]             step_sum;
  logic                   last_angle;

  // Saturating magnitude, saturating accumulate and best-candidate selection.
  always_comb begin
    sample_neg      = dss_audio_in[AUDIO_WIDTH-1];
    sample_most_neg = sample_neg && (dss_audio_in[AUDIO_WIDTH-2:0] == '0);
    if (sample_most_neg) begin
      sample_mag = {1'b0, {(AUDIO_WIDTH-1){1'b1}}};
    end else if (sample_neg) begin
      sample_mag = ~dss_audio_in + AUDIO_ONE;
    end else begin
      sample_mag = dss_audio_in;
    end
    acc_sum     = {1'b0, acc} + {{(ACC_WIDTH+1-AUDIO_WIDTH){1'b0}}, sample_mag};
    acc_sat     = acc_sum[ACC_WIDTH] ? '1 : acc_sum[ACC_WIDTH-1:0];
    better      = acc > scratch_energy;
    cand_angle  = better ? angle_out : scratch_angle;
    cand_energy = better ? acc : scratch_energy;
    step_sum    = {1'b0, angle_out} + ANGLE_STEP9;
    last_angle  = step_sum > ANGLE_MAX9;
  end

  // Next-state and next-output logic for the sweep sequencer.
  always_comb begin
    state_nxt          = state;
    cnt_nxt            = cnt;
    acc_nxt            = acc;
    scratch_angle_nxt  = scratch_angle;
    scratch_energy_nxt = scratch_energy;
    angle_nxt          = angle_out;
    busy_nxt           = busy_out;
    energy_nxt         = energy_out;
    energy_valid_nxt   = 1'b0;
    best_angle_nxt     = best_angle_out;
    best_energy_nxt    = best_energy_out;
    done_nxt           = 1'b0;

    case (state)
      IDLE: begin
        if (manual_mode_in) begin
          angle_nxt = manual_angle_in;
        end
        if (start_in && !abort_in) begin
          angle_nxt          = ANGLE_MIN8;
          cnt_nxt            = '0;
          scratch_angle_nxt  = ANGLE_MIN8;
          scratch_energy_nxt = '0;
          busy_nxt           = 1'b1;
          state_nxt          = SETTLE;
        end
      end
      SETTLE: begin
        if (abort_in) begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else if (dss_valid_in) begin
          if (cnt == SETTLE_LAST) begin
            cnt_nxt   = '0;
            acc_nxt   = '0;
            state_nxt = DWELL;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      end
      DWELL: begin
        if (abort_in) begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else if (dss_valid_in) begin
          acc_nxt = acc_sat;
          if (cnt == DWELL_LAST) begin
            cnt_nxt   = '0;
            state_nxt = COMPARE;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      end
      COMPARE: begin
        if (abort_in) begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          energy_nxt         = acc;
          energy_valid_nxt   = 1'b1;
          scratch_angle_nxt  = cand_angle;
          scratch_energy_nxt = cand_energy;
          if (last_angle) begin
            best_angle_nxt  = cand_angle;
            best_energy_nxt = cand_energy;
            done_nxt        = 1'b1;
            busy_nxt        = 1'b0;
            angle_nxt       = manual_mode_in ? manual_angle_in : cand_angle;
            state_nxt       = IDLE;
          end else begin
            angle_nxt = step_sum[7:0];
            state_nxt = SETTLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state            <= IDLE;
      cnt              <= '0;
      acc              <= '0;
      scratch_angle    <= ANGLE_MIN8;
      scratch_energy   <= '0;
      angle_out        <= ANGLE_MIN8;
      busy_out         <= 1'b0;
      energy_out       <= '0;
      energy_valid_out <= 1'b0;
      best_angle_out   <= ANGLE_MIN8;
      best_energy_out  <= '0;
      done_out         <= 1'b0;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      acc              <= acc_nxt;
      scratch_angle    <= scratch_angle_nxt;
      scratch_energy   <= scratch_energy_nxt;
      angle_out        <= angle_nxt;
      busy_out         <= busy_nxt;
      energy_out       <= energy_nxt;
      energy_valid_out <= energy_valid_nxt;
      best_angle_out   <= best_angle_nxt;
      best_energy_out  <= best_energy_nxt;
      done_out         <= done_nxt;
    end
  end

endmodule

// File: tb/tb_beam_scan_controller.sv
`timescale 1ns/1ps
// Bench for beam_scan_controller: directed sweeps against an energy/argmax model.
module tb_beam_scan_controller;

  localparam longint ACC_MAX = (longint'(1) << 40) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        manual = 1'b0;
  logic [7:0]  manual_angle = 8'd0;
  logic [23:0] audio = '0;
  logic        valid = 1'b0;

  logic [7:0]  angle_out;
  logic        busy_out;
  logic [39:0] energy_out;
  logic        energy_valid_out;
  logic [7:0]  best_angle_out;
  logic [39:0] best_energy_out;
  logic        done_out;

  beam_scan_controller #(
    .ANGLE_MIN(0), .ANGLE_MAX(20), .ANGLE_STEP(10),
    .SETTLE_SAMPLES(2), .DWELL_SAMPLES(4),
    .AUDIO_WIDTH(24), .ACC_WIDTH(40)
  ) dut (
    .clk_in(clk), .rst_in(rst_n), .start_in(start), .abort_in(abort),
    .manual_mode_in(manual), .manual_angle_in(manual_angle),
    .dss_audio_in(audio), .dss_valid_in(valid),
    .angle_out(angle_out), .busy_out(busy_out), .energy_out(energy_out),
    .energy_valid_out(energy_valid_out), .best_angle_out(best_angle_out),
    .best_energy_out(best_energy_out), .done_out(done_out)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  longint exp_energy_q[$];
  longint exp_best_e_q[$];
  int     exp_best_a_q[$];
  int     model_best_a = 0;
  longint model_best_e = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint mag_of(input logic [23:0] x);
    longint v;
    v = longint'($signed(x));
    if (v < 0) v = -v;
    if (v > 8388607) v = 8388607;
    return v;
  endfunction

  function automatic longint dwell_energy(input logic [23:0] s [4]);
    longint sum;
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      sum = sum + mag_of(s[i]);
      if (sum > ACC_MAX) sum = ACC_MAX;
    end
    return sum;
  endfunction

  // Compare process: energy pulses, done pulses and held best_* every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (energy_valid_out) begin
        if (exp_energy_q.size() == 0) chk("unexpected_energy_valid", 1, 0);
        else chk("energy_out", energy_out, exp_energy_q.pop_front());
      end
      if (done_out) begin
        if (exp_best_a_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          model_best_a = exp_best_a_q.pop_front();
          model_best_e = exp_best_e_q.pop_front();
          chk("busy_at_done", busy_out, 0);
        end
      end
      chk("best_angle_out", best_angle_out, model_best_a);
      chk("best_energy_out", best_energy_out, model_best_e);
    end
  end

  task automatic strobe(input logic [23:0] x);
    audio = x;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Two settle strobes, four dwell strobes, then the compare cycle.
  task automatic run_angle(input logic [23:0] s [4], input bit junk_in_compare);
    exp_energy_q.push_back(dwell_energy(s));
    strobe(24'd9999);
    strobe(24'd9999);
    for (int i = 0; i < 4; i++) strobe(s[i]);
    chk("energy_valid_not_early", energy_valid_out, 0);
    if (junk_in_compare) strobe(24'h7FFFFF);
    else @(negedge clk);
    chk("energy_valid_latency", energy_valid_out, 1);
  endtask

  task automatic do_sweep(input logic [23:0] smp [3][4], input bit junk, input bit start_busy);
    longint e;
    longint best_e;
    int     best_a;
    best_e = 0;
    best_a = 0;
    for (int i = 0; i < 3; i++) begin
      e = dwell_energy(smp[i]);
      if (e > best_e) begin
        best_e = e;
        best_a = i * 10;
      end
    end
    exp_best_a_q.push_back(best_a);
    exp_best_e_q.push_back(best_e);
    pulse_start();
    chk("busy_after_start", busy_out, 1);
    chk("angle_after_start", angle_out, 0);
    for (int i = 0; i < 3; i++) begin
      if (i == 1 && start_busy) begin
        pulse_start();
        chk("start_while_busy_angle", angle_out, 10);
        chk("start_while_busy_busy", busy_out, 1);
      end
      run_angle(smp[i], junk);
      chk("angle_after_compare", angle_out, (i < 2) ? (i + 1) * 10 : best_a);
      chk("done_timing", done_out, (i == 2) ? 1 : 0);
    end
    @(negedge clk);
    chk("done_pulse_width", done_out, 0);
    chk("energy_valid_pulse_width", energy_valid_out, 0);
  endtask

  logic [23:0] sw1 [3][4];
  logic [23:0] sw2 [3][4];
  logic [23:0] one [4];

  initial begin
    sw1 = '{'{24'd100, -24'sd100, 24'd100, -24'sd100},
            '{-24'sd500, 24'd500, -24'sd500, 24'd500},
            '{24'd300, -24'sd300, -24'sd300, 24'd300}};
    sw2 = '{'{24'h800000, 24'h800000, 24'h800000, 24'h800000},
            '{24'h800000, 24'h800000, 24'h800000, 24'h800000},
            '{24'h800000, 24'h800000, 24'h800000, 24'h800000}};
    one = '{24'd50, -24'sd50, 24'd50, -24'sd50};

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_angle", angle_out, 0);
    chk("reset_busy", busy_out, 0);
    chk("reset_best_angle", best_angle_out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Strobes in IDLE are ignored.
    for (int i = 0; i < 8; i++) strobe(24'd1234);
    chk("idle_ignores_valid", busy_out, 0);

    // Mixed-sign sweep, compare-cycle junk strobe, start while busy.
    do_sweep(sw1, 1'b1, 1'b1);
    chk("sweep1_energy_last", energy_out, 1200);
    chk("sweep1_best_angle", best_angle_out, 10);
    chk("sweep1_best_energy", best_energy_out, 2000);
    chk("sweep1_idle_angle", angle_out, 10);
    chk("sweep1_busy", busy_out, 0);

    // Most-negative samples saturate |x|; equal energies keep the first angle.
    do_sweep(sw2, 1'b0, 1'b0);
    chk("sat_energy", energy_out, 33554428);
    chk("tie_best_angle", best_angle_out, 0);
    chk("tie_best_energy", best_energy_out, 33554428);
    chk("tie_idle_angle", angle_out, 0);

    // Abort in SETTLE of angle 10.
    pulse_start();
    run_angle(one, 1'b0);
    chk("abort_pre_energy", energy_out, 200);
    strobe(24'd9999);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy_out, 0);
    chk("abort_done", done_out, 0);
    chk("abort_angle_holds", angle_out, 10);
    for (int i = 0; i < 8; i++) strobe(24'd777);
    chk("abort_stays_idle", busy_out, 0);
    chk("abort_best_angle", best_angle_out, 0);
    chk("abort_best_energy", best_energy_out, 33554428);

    // start and abort together in IDLE.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", busy_out, 0);
    for (int i = 0; i < 8; i++) strobe(24'd555);
    chk("start_abort_no_sweep", busy_out, 0);

    // Manual angle follows with one cycle latency.
    manual = 1'b1;
    manual_angle = 8'd45;
    #1 chk("manual_not_yet", angle_out, 10);
    @(negedge clk);
    chk("manual_45", angle_out, 45);
    manual_angle = 8'd77;
    @(negedge clk);
    chk("manual_77", angle_out, 77);
    manual = 1'b0;
    manual_angle = 8'd3;
    @(negedge clk);
    chk("manual_off_holds", angle_out, 77);

    // Reset mid-DWELL clears immediately, without a clock edge.
    pulse_start();
    strobe(24'd9999);
    strobe(24'd9999);
    strobe(24'd1000);
    strobe(24'd1000);
    chk("pre_reset_busy", busy_out, 1);
    #2;
    model_best_a = 0;
    model_best_e = 0;
    exp_energy_q.delete();
    exp_best_a_q.delete();
    exp_best_e_q.delete();
    rst_n = 1'b0;
    #1;
    chk("async_reset_angle", angle_out, 0);
    chk("async_reset_busy", busy_out, 0);
    chk("async_reset_energy", energy_out, 0);
    chk("async_reset_energy_valid", energy_valid_out, 0);
    chk("async_reset_best_angle", best_angle_out, 0);
    chk("async_reset_best_energy", best_energy_out, 0);
    chk("async_reset_done", done_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_busy", busy_out, 0);

    chk("energy_queue_drained", exp_energy_q.size(), 0);
    chk("best_queue_drained", exp_best_a_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
